// File: rtl/fios_control_gen_pkg.sv
// Shared types and constants for the FIOS control generator and the PE delay chain.
// Holds the state encoding, the DSP OPMODE and mux-select values, and the strobe bundle.
package fios_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    A_B0          = 4'd1,
    RES_P_PRIME_0 = 4'd2,
    M_P0          = 4'd3,
    A_BJ          = 4'd4,
    M_PJ          = 4'd5,
    LAST_A_BJ     = 4'd6,
    LAST_M_PJ     = 4'd7,
    RES_SHIFT     = 4'd8
  } state_t;

  localparam logic [8:0] OPMODE_IDLE    = 9'b000010101;
  localparam logic [8:0] OPMODE_A_B0    = 9'b000000101;
  localparam logic [8:0] OPMODE_RES_PP  = 9'b110000101;
  localparam logic [8:0] OPMODE_M_P     = 9'b111100101;
  localparam logic [8:0] OPMODE_A_B     = 9'b000100101;
  localparam logic [8:0] OPMODE_LAST_MP = 9'b001100000;
  localparam logic [8:0] OPMODE_SHIFT   = 9'b000100000;

  localparam logic [1:0] MUX_A_SEL_0 = 2'd0;
  localparam logic [1:0] MUX_A_SEL_1 = 2'd1;
  localparam logic [1:0] MUX_A_SEL_2 = 2'd2;
  localparam logic [1:0] MUX_B_SEL_0 = 2'd0;
  localparam logic [1:0] MUX_B_SEL_1 = 2'd1;
  localparam logic [1:0] MUX_B_SEL_2 = 2'd2;
  localparam logic [1:0] MUX_C_SEL_0 = 2'd0;
  localparam logic [1:0] MUX_C_SEL_1 = 2'd1;

  typedef struct packed {
    logic       a_reg_en;
    logic       m_reg_en;
    logic       creg_en;
    logic       res_delay_en;
    logic       a_shift;
    logic       b_fetch;
    logic       p_fetch;
    logic       res_push;
    logic       done;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic [1:0] mux_c_sel;
    logic [8:0] opmode;
  } ctrl_t;

  // Moore decode; unknown encodings yield an all-zero bundle.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE: begin
        c.a_reg_en = 1'b1; c.creg_en = 1'b1; c.opmode = OPMODE_IDLE;
      end
      A_B0: begin
        c.mux_a_sel = MUX_A_SEL_1; c.mux_b_sel = MUX_B_SEL_1; c.mux_c_sel = MUX_C_SEL_1;
        c.creg_en = 1'b1; c.opmode = OPMODE_A_B0; c.a_shift = 1'b1;
      end
      RES_P_PRIME_0: begin
        c.m_reg_en = 1'b1; c.mux_a_sel = MUX_A_SEL_1; c.mux_b_sel = MUX_B_SEL_2;
        c.creg_en = 1'b1; c.opmode = OPMODE_RES_PP; c.b_fetch = 1'b1;
      end
      M_P0: begin
        c.opmode = OPMODE_M_P; c.p_fetch = 1'b1;
      end
      A_BJ: begin
        c.mux_a_sel = MUX_A_SEL_2; c.mux_b_sel = MUX_B_SEL_2;
        c.creg_en = 1'b1; c.opmode = OPMODE_A_B; c.b_fetch = 1'b1;
      end
      M_PJ: begin
        c.opmode = OPMODE_M_P; c.p_fetch = 1'b1; c.res_push = 1'b1; c.res_delay_en = 1'b1;
      end
      LAST_A_BJ: begin
        c.mux_a_sel = MUX_A_SEL_2; c.mux_b_sel = MUX_B_SEL_2;
        c.opmode = OPMODE_A_B; c.res_delay_en = 1'b1;
      end
      LAST_M_PJ: begin
        c.opmode = OPMODE_LAST_MP; c.res_push = 1'b1; c.res_delay_en = 1'b1;
      end
      RES_SHIFT: begin
        c.a_reg_en = 1'b1; c.opmode = OPMODE_SHIFT; c.res_push = 1'b1;
        c.done = 1'b1; c.res_delay_en = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fios_control_gen_if.sv
// Handshake and PE-strobe bundle between the FIOS control generator and the cascade.
// The master side issues operations; the slave side is the control FSM.
interface fios_control_gen_if #(parameter int S = 16);
  localparam int CNT_W = $clog2(S + 1);

  logic             start_i;
  logic [CNT_W-1:0] n_words_i;
  logic             ready_o;
  logic             err_o;
  logic [CNT_W-1:0] word_idx_o;
  logic             a_reg_en_o;
  logic             m_reg_en_o;
  logic             CREG_en_o;
  logic             RES_delay_en_o;
  logic             a_shift_o;
  logic             b_fetch_o;
  logic             p_fetch_o;
  logic             RES_push_o;
  logic             done_o;
  logic [1:0]       mux_A_sel_o;
  logic [1:0]       mux_B_sel_o;
  logic [1:0]       mux_C_sel_o;
  logic [8:0]       OPMODE_o;

  modport master (
    output start_i, n_words_i,
    input  ready_o, err_o, word_idx_o, a_reg_en_o, m_reg_en_o, CREG_en_o, RES_delay_en_o,
           a_shift_o, b_fetch_o, p_fetch_o, RES_push_o, done_o,
           mux_A_sel_o, mux_B_sel_o, mux_C_sel_o, OPMODE_o
  );

  modport slave (
    input  start_i, n_words_i,
    output ready_o, err_o, word_idx_o, a_reg_en_o, m_reg_en_o, CREG_en_o, RES_delay_en_o,
           a_shift_o, b_fetch_o, p_fetch_o, RES_push_o, done_o,
           mux_A_sel_o, mux_B_sel_o, mux_C_sel_o, OPMODE_o
  );
endinterface

// File: rtl/fios_control_gen_loop_counter.sv
// Word loop counter j for the FIOS sequence; flags the last inner iteration (j == n-2).
module fios_loop_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] n_words,
  output logic [CNT_W-1:0] count,
  output logic             eq_last
);
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count   = count_reg;
  assign eq_last = (count_reg == n_words - CNT_W'(2));
endmodule

// File: rtl/fios_control_gen.sv
// Runtime-length FIOS control FSM driving the first PE of the DSP cascade.
// Latches n per operation, supports back-to-back starts from RES_SHIFT and flags illegal lengths.
module fios_control_gen
  import fios_ctrl_pkg::*;
#(
  parameter int S    = 16,
  parameter int CREG = 0
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  fios_control_gen_if.slave  bus
);
  localparam int CNT_W = $clog2(S + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] n_reg;
  logic             err_reg;
  logic             ready, n_legal, start_ok;
  logic             cnt_clear, cnt_en, eq_last;
  logic [CNT_W-1:0] word_idx;
  ctrl_t            ctrl;

  // CREG only shapes the PE cascade; the sequence here is identical for every value.
  if (CREG != 0 && CREG != 1) begin : g_creg_passthrough
  end

  assign ready    = (state_reg == IDLE) || (state_reg == RES_SHIFT);
  assign n_legal  = (bus.n_words_i >= CNT_W'(2)) && (bus.n_words_i <= CNT_W'(S));
  assign start_ok = ready && bus.start_i && n_legal;

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:          state_next = start_ok ? A_B0 : IDLE;
      A_B0:          state_next = RES_P_PRIME_0;
      RES_P_PRIME_0: state_next = M_P0;
      M_P0:          state_next = (n_reg == CNT_W'(2)) ? LAST_A_BJ : A_BJ;
      A_BJ:          state_next = M_PJ;
      M_PJ:          state_next = eq_last ? LAST_A_BJ : A_BJ;
      LAST_A_BJ:     state_next = LAST_M_PJ;
      LAST_M_PJ:     state_next = RES_SHIFT;
      RES_SHIFT:     state_next = start_ok ? A_B0 : IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      n_reg     <= CNT_W'(S);
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_ok) n_reg <= bus.n_words_i;
      err_reg   <= ready && bus.start_i && !n_legal;
    end
  end

  // Anything outside the active loop (IDLE, RES_SHIFT, stray encodings) clears j.
  assign cnt_clear = !(state_reg inside {A_B0, RES_P_PRIME_0, M_P0, A_BJ, M_PJ, LAST_A_BJ, LAST_M_PJ});
  assign cnt_en    = state_reg inside {M_P0, M_PJ, LAST_M_PJ};

  fios_loop_counter #(.CNT_W(CNT_W)) u_loop_counter (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .clear     (cnt_clear),
    .en        (cnt_en),
    .n_words   (n_reg),
    .count     (word_idx),
    .eq_last   (eq_last)
  );

  assign ctrl = ctrl_decode(state_reg);

  assign bus.ready_o        = ready;
  assign bus.err_o          = err_reg;
  assign bus.word_idx_o     = word_idx;
  assign bus.a_reg_en_o     = ctrl.a_reg_en;
  assign bus.m_reg_en_o     = ctrl.m_reg_en;
  assign bus.CREG_en_o      = ctrl.creg_en;
  assign bus.RES_delay_en_o = ctrl.res_delay_en;
  assign bus.a_shift_o      = ctrl.a_shift;
  assign bus.b_fetch_o      = ctrl.b_fetch;
  assign bus.p_fetch_o      = ctrl.p_fetch;
  assign bus.RES_push_o     = ctrl.res_push;
  assign bus.done_o         = ctrl.done;
  assign bus.mux_A_sel_o    = ctrl.mux_a_sel;
  assign bus.mux_B_sel_o    = ctrl.mux_b_sel;
  assign bus.mux_C_sel_o    = ctrl.mux_c_sel;
  assign bus.OPMODE_o       = ctrl.opmode;
endmodule

// File: tb/tb_fios_control_gen.sv
// Scoreboard bench for fios_control_gen: operations are predicted from acceptance cycle and n,
// and a monitor compares the DUT's per-cycle outputs and per-operation strobe totals.
module tb_fios_control_gen;
  localparam int S = 16;

  localparam logic [23:0] ROW_IDLE = {9'b101000000, 6'b000000, 9'b000010101};
  localparam logic [23:0] ROW_A_B0 = {9'b001010000, 6'b010101, 9'b000000101};
  localparam logic [23:0] ROW_DONE = {9'b100100011, 6'b000000, 9'b000100000};

  typedef struct {
    int a;
    int n;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  op_t opq[$];
  int  errq[$];

  // Stimulus-side view of the operation in flight.
  bit act_valid = 1'b0;
  int act_a = 0;
  int act_n = 0;

  fios_control_gen_if #(.S(S)) bus ();

  fios_control_gen #(.S(S), .CREG(0)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic step(input bit st, input logic [4:0] nw, input bit rn);
    bit rdy;
    int c;
    @(negedge clk);
    c = cyc;
    if (!rn) begin
      act_valid = 1'b0;
      opq.delete();
      errq.delete();
    end else begin
      if (act_valid && c > act_a + 2 * act_n + 2) act_valid = 1'b0;
      rdy = !act_valid || (c == act_a + 2 * act_n + 2);
      if (st && rdy) begin
        if (nw >= 2 && nw <= S) begin
          opq.push_back('{a: c, n: int'(nw)});
          act_valid = 1'b1;
          act_a = c;
          act_n = int'(nw);
        end else begin
          errq.push_back(c + 1);
        end
      end
    end
    rst_n         = rn;
    bus.start_i   = st;
    bus.n_words_i = nw;
    $display("cycle %0d: start=%0b n=%0d rst_n=%0b", c, st, nw, rn);
  endtask

  // Monitor: samples 1ns after each rising edge.
  initial begin
    int k, dn, exp_idx;
    int cnt_b, cnt_p, cnt_push, cnt_sh;
    logic [23:0] row;
    cnt_b = 0; cnt_p = 0; cnt_push = 0; cnt_sh = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        row = {bus.a_reg_en_o, bus.m_reg_en_o, bus.CREG_en_o, bus.RES_delay_en_o, bus.a_shift_o,
               bus.b_fetch_o, bus.p_fetch_o, bus.RES_push_o, bus.done_o,
               bus.mux_A_sel_o, bus.mux_B_sel_o, bus.mux_C_sel_o, bus.OPMODE_o};
        if (opq.size() > 0 && cyc >= opq[0].a + 1) begin
          k  = cyc - opq[0].a;
          dn = 2 * opq[0].n + 2;
          exp_idx = (k <= 3) ? 0 : (k - 2) / 2;
          check("word_idx", 32'(bus.word_idx_o), 32'(exp_idx));
          check("ready_busy", 32'(bus.ready_o), 32'(k == dn));
          cnt_b    += int'(bus.b_fetch_o);
          cnt_p    += int'(bus.p_fetch_o);
          cnt_push += int'(bus.RES_push_o);
          cnt_sh   += int'(bus.a_shift_o);
          if (k == 1) check("row_a_b0", 32'(row), 32'(ROW_A_B0));
          if (k == dn) begin
            check("row_done", 32'(row), 32'(ROW_DONE));
            check("b_fetch_count", 32'(cnt_b), 32'(opq[0].n - 1));
            check("p_fetch_count", 32'(cnt_p), 32'(opq[0].n - 1));
            check("res_push_count", 32'(cnt_push), 32'(opq[0].n));
            check("a_shift_count", 32'(cnt_sh), 32'd1);
            $display("op n=%0d accepted %0d done at %0d", opq[0].n, opq[0].a, cyc);
            void'(opq.pop_front());
            cnt_b = 0; cnt_p = 0; cnt_push = 0; cnt_sh = 0;
          end else begin
            check("done_early", 32'(bus.done_o), 32'd0);
          end
        end else begin
          check("idle_row", 32'(row), 32'(ROW_IDLE));
          check("idle_word_idx", 32'(bus.word_idx_o), 32'd0);
          check("idle_ready", 32'(bus.ready_o), 32'd1);
          cnt_b = 0; cnt_p = 0; cnt_push = 0; cnt_sh = 0;
        end
        if (errq.size() > 0 && errq[0] == cyc) begin
          check("err_pulse", 32'(bus.err_o), 32'd1);
          void'(errq.pop_front());
        end else begin
          check("err_quiet", 32'(bus.err_o), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.start_i   = 1'b0;
    bus.n_words_i = '0;
    repeat (3) step(1'b0, 5'd0, 1'b0);
    mon_en = 1'b1;
    repeat (2) step(1'b0, 5'd0, 1'b1);

    // Full-length op, then the shortest legal op.
    step(1'b1, 5'd16, 1'b1);
    repeat (38) step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd2, 1'b1);
    repeat (8) step(1'b0, 5'd0, 1'b1);

    // Illegal lengths in IDLE.
    step(1'b1, 5'd1, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd17, 1'b1);
    repeat (2) step(1'b0, 5'd0, 1'b1);

    // Back-to-back: n=4 presented exactly in the RES_SHIFT cycle of an n=16 op.
    step(1'b1, 5'd16, 1'b1);
    repeat (33) step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd4, 1'b1);
    repeat (12) step(1'b0, 5'd0, 1'b1);

    // Reset during M_PJ with j=5 of an n=8 op.
    step(1'b1, 5'd8, 1'b1);
    repeat (12) step(1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b0);
    repeat (4) step(1'b0, 5'd0, 1'b1);

    // Start held high while n toggles between 3 and 5.
    for (int i = 0; i < 40; i++) step(1'b1, (i % 2 == 1) ? 5'd5 : 5'd3, 1'b1);
    repeat (15) step(1'b0, 5'd0, 1'b1);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 18)), $urandom_range(0, 149) != 0);

    repeat (50) step(1'b0, 5'd0, 1'b1);
    @(negedge clk);
    check("ops_drained", 32'(opq.size()), 32'd0);
    check("errs_drained", 32'(errq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
